// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit:
// state encoding, opcodes, ALUOp and mux select constants, control bundle.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ADDIWB = 4'd12
    } ctrl_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       inst_done;
        logic       illegal;
    } ctrl_out_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: op_is_legal = 1'b1;
            default:                                       op_is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, stalling on memory via mem_ready.
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic [1:0] PCSource,
    output logic       inst_done,
    output logic       illegal,
    output logic [3:0] state
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    ctrl_out_t   ctrl;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; op is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (op)
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEMADR: state_d = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  state_d = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; mem_ready only gates the FETCH and MEMWR commits.
    always_comb begin
        ctrl = '0;
        case (state_q)
            ST_IDLE: begin
                ctrl = '0;
            end
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH2;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.illegal   = ~op_is_legal(op);
            end
            ST_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            ST_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.inst_done  = 1'b1;
            end
            ST_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                ctrl.inst_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.inst_done     = 1'b1;
            end
            ST_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.inst_done = 1'b1;
            end
            ST_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.inst_done = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp1      = ctrl.alu_op[1];
    assign ALUOp0      = ctrl.alu_op[0];
    assign PCSource    = ctrl.pc_source;
    assign inst_done   = ctrl.inst_done;
    assign illegal     = ctrl.illegal;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vector table for the multicycle control FSM, plus
// end-to-end latency runs for each supported instruction.
module tb_multicycle_ctrl;
    import cpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, ALUOp1, ALUOp0;
    logic       inst_done, illegal;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0),
        .PCSource(PCSource), .inst_done(inst_done), .illegal(illegal),
        .state(state)
    );

    // Packed control view: PCW PCWC IorD MR MW IRW M2R RD RW SA SB[2] AO1 AO0 PS[2] done ill
    logic [17:0] act;
    assign act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp1, ALUOp0, PCSource,
                  inst_done, illegal};

    localparam logic [17:0] E_IDLE    = 18'b0;
    localparam logic [17:0] E_FETCH_R = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_FETCH_S = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DEC     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_DEC_ILL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,1'b0,2'b00,1'b0,1'b1};
    localparam logic [17:0] E_MEMADR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_MEMWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MEMWR_D = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_MEMWR_S = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_EXEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b1,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ALUWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};
    localparam logic [17:0] E_BRANCH  = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b1,2'b01,1'b1,1'b0};
    localparam logic [17:0] E_JUMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,2'b10,1'b1,1'b0};
    localparam logic [17:0] E_ADDIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,2'b00,1'b0,1'b0};
    localparam logic [17:0] E_ADDIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0};

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  st;
        logic [17:0] ctl;
    } vec_t;

    localparam int NV = 37;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [5:0] o, input logic m,
                                input ctrl_state_t s, input logic [17:0] c);
        vec_t v;
        v.rst = r; v.op = o; v.mr = m; v.st = s; v.ctl = c;
        return v;
    endfunction

    task automatic check_vec(input int idx, input vec_t v);
        total++;
        if (state !== v.st) begin
            bad++;
            $display("FAIL state[%0d]: got %0d expected %0d", idx, state, v.st);
        end
        total++;
        if (act !== v.ctl) begin
            bad++;
            $display("FAIL ctrl[%0d]: got %b expected %b", idx, act, v.ctl);
        end
    endtask

    // Reset, then count cycles from FETCH until inst_done with mem_ready tied high.
    task automatic run_latency(input logic [5:0] o, input int exp_cyc);
        int cyc;
        @(negedge clk); rst = 1'b1; mem_ready = 1'b1; op = o;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        cyc = 1;
        while (inst_done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != exp_cyc) begin
            bad++;
            $display("FAIL latency op=%b: got %0d cycles expected %0d", o, cyc, exp_cyc);
        end
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 6'b000000, 1'b0, ST_IDLE,   E_IDLE);
        vecs[1]  = mk(1'b0, 6'b000000, 1'b0, ST_IDLE,   E_IDLE);
        vecs[2]  = mk(1'b0, 6'b000000, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[3]  = mk(1'b0, 6'b000000, 1'b1, ST_DECODE, E_DEC);
        vecs[4]  = mk(1'b0, 6'b100011, 1'b1, ST_EXEC,   E_EXEC);
        vecs[5]  = mk(1'b0, 6'b100011, 1'b1, ST_ALUWB,  E_ALUWB);
        vecs[6]  = mk(1'b0, 6'b100011, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[7]  = mk(1'b0, 6'b100011, 1'b1, ST_DECODE, E_DEC);
        vecs[8]  = mk(1'b0, 6'b100011, 1'b1, ST_MEMADR, E_MEMADR);
        vecs[9]  = mk(1'b0, 6'b100011, 1'b0, ST_MEMRD,  E_MEMRD);
        vecs[10] = mk(1'b0, 6'b100011, 1'b0, ST_MEMRD,  E_MEMRD);
        vecs[11] = mk(1'b0, 6'b100011, 1'b1, ST_MEMRD,  E_MEMRD);
        vecs[12] = mk(1'b0, 6'b100011, 1'b1, ST_MEMWB,  E_MEMWB);
        vecs[13] = mk(1'b0, 6'b101011, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[14] = mk(1'b0, 6'b101011, 1'b1, ST_DECODE, E_DEC);
        vecs[15] = mk(1'b0, 6'b101011, 1'b1, ST_MEMADR, E_MEMADR);
        vecs[16] = mk(1'b0, 6'b101011, 1'b1, ST_MEMWR,  E_MEMWR_D);
        vecs[17] = mk(1'b0, 6'b000100, 1'b0, ST_FETCH,  E_FETCH_S);
        vecs[18] = mk(1'b0, 6'b000100, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[19] = mk(1'b0, 6'b000100, 1'b1, ST_DECODE, E_DEC);
        vecs[20] = mk(1'b0, 6'b000100, 1'b1, ST_BRANCH, E_BRANCH);
        vecs[21] = mk(1'b0, 6'b000010, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[22] = mk(1'b0, 6'b000010, 1'b1, ST_DECODE, E_DEC);
        vecs[23] = mk(1'b0, 6'b000010, 1'b1, ST_JUMP,   E_JUMP);
        vecs[24] = mk(1'b0, 6'b001000, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[25] = mk(1'b0, 6'b001000, 1'b1, ST_DECODE, E_DEC);
        vecs[26] = mk(1'b0, 6'b001000, 1'b1, ST_ADDIEX, E_ADDIEX);
        vecs[27] = mk(1'b0, 6'b001000, 1'b1, ST_ADDIWB, E_ADDIWB);
        vecs[28] = mk(1'b0, 6'b111111, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[29] = mk(1'b0, 6'b111111, 1'b1, ST_DECODE, E_DEC_ILL);
        vecs[30] = mk(1'b0, 6'b111111, 1'b1, ST_FETCH,  E_FETCH_R);
        vecs[31] = mk(1'b0, 6'b101011, 1'b1, ST_DECODE, E_DEC);
        vecs[32] = mk(1'b0, 6'b101011, 1'b1, ST_MEMADR, E_MEMADR);
        vecs[33] = mk(1'b0, 6'b101011, 1'b0, ST_MEMWR,  E_MEMWR_S);
        vecs[34] = mk(1'b1, 6'b101011, 1'b0, ST_MEMWR,  E_MEMWR_S);
        vecs[35] = mk(1'b0, 6'b101011, 1'b0, ST_IDLE,   E_IDLE);
        vecs[36] = mk(1'b0, 6'b101011, 1'b1, ST_FETCH,  E_FETCH_R);

        rst = 1'b1; op = 6'b000000; mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; op = vecs[i].op; mem_ready = vecs[i].mr;
            #1;
            check_vec(i, vecs[i]);
        end

        run_latency(6'b000000, 4);
        run_latency(6'b100011, 5);
        run_latency(6'b101011, 4);
        run_latency(6'b000100, 3);
        run_latency(6'b000010, 3);
        run_latency(6'b001000, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
